// File: rtl/vec_core.sv
// rtl/vec_core.sv - SIMD vector core: read two operand vectors, apply a lane-wise op, write the result
// Loops over len elements, walking src1/src2/dst addresses upward with wrap.
module vec_core #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_instr_valid,
  output logic                      o_instr_ready,
  input  logic [2+LEN_W+3*ADDR_W-1:0] i_instr,
  output logic                      o_idle,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_rd_req,
  output logic [ADDR_W-1:0]         o_rd_addr,
  input  logic                      i_rd_valid,
  input  logic [LANES*DATA_W-1:0]   i_rd_data,
  output logic                      o_wr_req,
  output logic [ADDR_W-1:0]         o_wr_addr,
  output logic [LANES*DATA_W-1:0]   o_wr_data,
  input  logic                      i_wr_ack
);

  localparam int VW = LANES * DATA_W;
  localparam int IW = 2 + LEN_W + 3 * ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD2, S_EXEC, S_WR, S_DONE
  } state_t;

  state_t            r_state;
  logic [LEN_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_a1, r_a2, r_ad;
  logic [1:0]        r_op;
  logic [VW-1:0]     r_opa, r_opb, r_res;

  logic [ADDR_W-1:0] w_src1, w_src2, w_dst;
  logic [LEN_W-1:0]  w_len;
  logic [1:0]        w_op;
  logic [VW-1:0]     w_alu;

  assign w_src1 = i_instr[ADDR_W-1:0];
  assign w_src2 = i_instr[2*ADDR_W-1:ADDR_W];
  assign w_dst  = i_instr[3*ADDR_W-1:2*ADDR_W];
  assign w_len  = i_instr[3*ADDR_W+LEN_W-1:3*ADDR_W];
  assign w_op   = i_instr[IW-1:IW-2];

  // Each lane is computed in isolation, so no carry crosses a lane boundary.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_W-1:0] w_a, w_b, w_mul;
    assign w_a   = r_opa[g*DATA_W +: DATA_W];
    assign w_b   = r_opb[g*DATA_W +: DATA_W];
    assign w_mul = w_a * w_b;
    assign w_alu[g*DATA_W +: DATA_W] =
        (r_op == 2'b00) ? w_a + w_b :
        (r_op == 2'b01) ? w_a - w_b :
        (r_op == 2'b10) ? w_mul :
        (($signed(w_a) > $signed(w_b)) ? w_a : w_b);
  end

  assign o_instr_ready = (r_state == S_IDLE) & i_en & ~i_rst;
  assign o_idle        = (r_state == S_IDLE);
  assign o_busy        = (r_state == S_RD1) | (r_state == S_RD2) |
                         (r_state == S_EXEC) | (r_state == S_WR);
  assign o_done        = (r_state == S_DONE);

  // Bus outputs decode from state registers only, and read as zero when idle.
  assign o_rd_req  = (r_state == S_RD1) | (r_state == S_RD2);
  assign o_rd_addr = (r_state == S_RD1) ? r_a1 :
                     (r_state == S_RD2) ? r_a2 : '0;
  assign o_wr_req  = (r_state == S_WR);
  assign o_wr_addr = (r_state == S_WR) ? r_ad : '0;
  assign o_wr_data = (r_state == S_WR) ? r_res : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_a1    <= '0;
      r_a2    <= '0;
      r_ad    <= '0;
      r_op    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_instr_valid && i_en) begin
            r_count <= w_len;
            r_a1    <= w_src1;
            r_a2    <= w_src2;
            r_ad    <= w_dst;
            r_op    <= w_op;
            r_state <= (w_len == '0) ? S_DONE : S_RD1;
          end
        end
        S_RD1: begin
          if (i_rd_valid) begin
            r_opa   <= i_rd_data;
            r_state <= S_RD2;
          end
        end
        S_RD2: begin
          if (i_rd_valid) begin
            r_opb   <= i_rd_data;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= w_alu;
          r_state <= S_WR;
        end
        S_WR: begin
          if (i_wr_ack) begin
            r_a1    <= r_a1 + ADDR_W'(1);
            r_a2    <= r_a2 + ADDR_W'(1);
            r_ad    <= r_ad + ADDR_W'(1);
            r_count <= r_count - LEN_W'(1);
            r_state <= (r_count == LEN_W'(1)) ? S_DONE : S_RD1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_core.sv
// tb/tb_vec_core.sv - self-checking bench for vec_core against a lane-wise reference model
module tb_vec_core;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_en = 1'b0;
  logic         i_instr_valid = 1'b0;
  logic         o_instr_ready;
  logic [57:0]  i_instr = '0;
  logic         o_idle, o_busy, o_done;
  logic         o_rd_req;
  logic [15:0]  o_rd_addr;
  logic         i_rd_valid = 1'b0;
  logic [127:0] i_rd_data = '0;
  logic         o_wr_req;
  logic [15:0]  o_wr_addr;
  logic [127:0] o_wr_data;
  logic         i_wr_ack = 1'b0;

  vec_core dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready), .i_instr(i_instr),
    .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
    .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .i_wr_ack(i_wr_ack)
  );

  initial forever #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_delay = 0, wr_delay = 0;
  int done_cnt = 0;

  logic [127:0] mem [logic [15:0]];
  logic [127:0] mdl [logic [15:0]];
  logic [15:0]  rd_log[$], wr_log_addr[$], exp_rd[$], exp_wa[$];
  logic [127:0] wr_log_data[$], exp_wd[$];

  initial forever @(posedge i_clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 128'd0;
  endfunction

  function automatic logic [127:0] mdl_rd(input logic [15:0] a);
    return mdl.exists(a) ? mdl[a] : 128'd0;
  endfunction

  function automatic logic [127:0] ref_op(input logic [1:0] op, input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    logic [31:0]  x, y, z;
    logic [63:0]  p;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      x = a[l*32 +: 32];
      y = b[l*32 +: 32];
      p = {32'd0, x} * {32'd0, y};
      case (op)
        2'd0: z = x + y;
        2'd1: z = x - y;
        2'd2: z = p[31:0];
        default: z = ($signed(x) > $signed(y)) ? x : y;
      endcase
      r[l*32 +: 32] = z;
    end
    return r;
  endfunction

  // Memory responder: programmable read/write latency, checks bus rules every cycle.
  initial begin
    int rd_cnt, wr_cnt;
    logic [15:0]  rd_hold, wr_hold;
    logic [127:0] wd_hold;
    rd_cnt = 0; wr_cnt = 0; rd_hold = '0; wr_hold = '0; wd_hold = '0;
    forever begin
      @(negedge i_clk);
      if (i_rd_valid) rd_cnt = 0;
      if (i_wr_ack) wr_cnt = 0;
      chk("req_exclusive", o_rd_req & o_wr_req, 0);
      if (o_done) done_cnt++;
      if (o_rd_req) begin
        if (rd_cnt == 0) rd_hold = o_rd_addr;
        else chk("rd_addr_stable", o_rd_addr, rd_hold);
        if (rd_cnt >= rd_delay) begin
          i_rd_valid = 1'b1;
          i_rd_data = mem_rd(o_rd_addr);
          rd_log.push_back(o_rd_addr);
        end else begin
          i_rd_valid = 1'b0;
          rd_cnt++;
        end
      end else begin
        chk("rd_addr_zero", o_rd_addr, 0);
        i_rd_valid = ($urandom_range(0, 3) == 0);
        i_rd_data = {$urandom, $urandom, $urandom, $urandom};
        rd_cnt = 0;
      end
      if (o_wr_req) begin
        if (wr_cnt == 0) begin
          wr_hold = o_wr_addr;
          wd_hold = o_wr_data;
        end else begin
          chk("wr_addr_stable", o_wr_addr, wr_hold);
          chk("wr_data_stable", o_wr_data, wd_hold);
        end
        if (wr_cnt >= wr_delay) begin
          i_wr_ack = 1'b1;
          wr_log_addr.push_back(o_wr_addr);
          wr_log_data.push_back(o_wr_data);
          mem[o_wr_addr] = o_wr_data;
        end else begin
          i_wr_ack = 1'b0;
          wr_cnt++;
        end
      end else begin
        chk("wr_addr_zero", o_wr_addr, 0);
        chk("wr_data_zero", o_wr_data, 0);
        i_wr_ack = 1'b0;
        wr_cnt = 0;
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete(); wr_log_addr.delete(); wr_log_data.delete();
    done_cnt = 0;
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [7:0] len, input logic [15:0] s1,
                           input logic [15:0] s2, input logic [15:0] d, input int rdd, input int wrd,
                           input string tag);
    int acc, to, lat, exp_lat, n;
    logic [127:0] r;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    mdl = mem;
    for (int k = 0; k < int'(len); k++) begin
      exp_rd.push_back(s1 + 16'(k));
      exp_rd.push_back(s2 + 16'(k));
      r = ref_op(op, mdl_rd(s1 + 16'(k)), mdl_rd(s2 + 16'(k)));
      mdl[d + 16'(k)] = r;
      exp_wa.push_back(d + 16'(k));
      exp_wd.push_back(r);
    end
    exp_lat = (len == 0) ? 2 : 2 + int'(len) * (4 + 2 * rdd + wrd);
    rd_delay = rdd; wr_delay = wrd;
    @(negedge i_clk);
    clear_logs();
    i_en = 1'b1;
    i_instr = {op, len, d, s2, s1};
    i_instr_valid = 1'b1;
    #1 chk({tag, "_ready"}, o_instr_ready, 1);
    acc = cyc;
    @(negedge i_clk);
    i_instr_valid = 1'b0;
    to = 0;
    while (!o_done && to < 600) begin
      @(negedge i_clk);
      to++;
    end
    chk({tag, "_no_timeout"}, to < 600, 1);
    lat = cyc - acc + 1;
    chk({tag, "_latency"}, lat, exp_lat);
    @(negedge i_clk);
    chk({tag, "_done_pulse_end"}, o_done, 0);
    chk({tag, "_idle_after"}, o_idle, 1);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_rd_count"}, rd_log.size(), exp_rd.size());
    chk({tag, "_wr_count"}, wr_log_addr.size(), exp_wa.size());
    n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
    for (int k = 0; k < n; k++) chk($sformatf("%s_rd_addr%0d", tag, k), rd_log[k], exp_rd[k]);
    n = (wr_log_addr.size() < exp_wa.size()) ? wr_log_addr.size() : exp_wa.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_wr_addr%0d", tag, k), wr_log_addr[k], exp_wa[k]);
      chk($sformatf("%s_wr_data%0d", tag, k), wr_log_data[k], exp_wd[k]);
    end
  endtask

  initial begin
    int to;
    // Reset with all inputs low.
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_idle", o_idle, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ready", o_instr_ready, 0);
    chk("rst_rd_req", o_rd_req, 0);
    chk("rst_wr_req", o_wr_req, 0);
    chk("rst_wr_data", o_wr_data, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("ready_en_low", o_instr_ready, 0);

    // Element-wise add, zero-wait memory.
    mem[16'h0010] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem[16'h0020] = {32'd40, 32'd30, 32'd20, 32'd10};
    run_instr(2'd0, 8'd1, 16'h0010, 16'h0020, 16'h0030, 0, 0, "add");
    if (wr_log_data.size() > 0) chk("add_result", wr_log_data[0], {32'd44, 32'd33, 32'd22, 32'd11});
    if (wr_log_addr.size() > 0) chk("add_dst", wr_log_addr[0], 16'h0030);

    // Subtract with address wrap on every pointer.
    mem[16'hFFFF] = {32'd9, 32'd9, 32'd0, 32'd0};
    mem[16'h0000] = {32'd3, 32'd2, 32'd1, 32'd1};
    mem[16'h0001] = {32'd5, 32'd6, 32'd7, 32'd8};
    run_instr(2'd1, 8'd3, 16'hFFFF, 16'h0000, 16'hFFFE, 0, 0, "sub");
    if (wr_log_data.size() == 3) begin
      chk("sub_lane01", wr_log_data[0][63:0], 64'hFFFFFFFF_FFFFFFFF);
      chk("sub_wa0", wr_log_addr[0], 16'hFFFE);
      chk("sub_wa1", wr_log_addr[1], 16'hFFFF);
      chk("sub_wa2", wr_log_addr[2], 16'h0000);
    end
    if (rd_log.size() == 6) begin
      chk("sub_ra0", rd_log[0], 16'hFFFF);
      chk("sub_ra2", rd_log[2], 16'h0000);
      chk("sub_ra4", rd_log[4], 16'h0001);
    end

    // Multiply wrap and signed max with slow memory.
    mem[16'h0100] = {4{32'h0001_0000}};
    mem[16'h0101] = {4{32'h0001_0000}};
    run_instr(2'd2, 8'd1, 16'h0100, 16'h0101, 16'h0102, 3, 2, "mul");
    if (wr_log_data.size() > 0) chk("mul_result", wr_log_data[0], 128'd0);
    mem[16'h0200] = {4{32'hFFFF_FFFF}};
    mem[16'h0201] = {4{32'd1}};
    run_instr(2'd3, 8'd1, 16'h0200, 16'h0201, 16'h0300, 3, 2, "max");
    if (wr_log_data.size() > 0) chk("max_result", wr_log_data[0], {4{32'd1}});

    // Zero-length instruction: no memory traffic.
    run_instr(2'd0, 8'd0, 16'h0010, 16'h0020, 16'h0030, 0, 0, "len0");

    // Held instruction with the core disabled is never taken.
    @(negedge i_clk);
    clear_logs();
    i_en = 1'b0;
    i_instr = {2'd0, 8'd2, 16'h0030, 16'h0020, 16'h0010};
    i_instr_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      chk("dis_ready", o_instr_ready, 0);
      chk("dis_idle", o_idle, 1);
    end
    i_instr_valid = 1'b0;
    chk("dis_no_reads", rd_log.size(), 0);
    chk("dis_no_done", done_cnt, 0);

    // Reset while a write is pending aborts without a done pulse.
    rd_delay = 0; wr_delay = 50;
    clear_logs();
    i_en = 1'b1;
    i_instr = {2'd0, 8'd4, 16'h0400, 16'h0020, 16'h0010};
    i_instr_valid = 1'b1;
    @(negedge i_clk);
    i_instr_valid = 1'b0;
    to = 0;
    while (!o_wr_req && to < 50) begin
      @(negedge i_clk);
      to++;
    end
    chk("abort_reach_wr", o_wr_req, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("abort_wr_req", o_wr_req, 0);
    chk("abort_rd_req", o_rd_req, 0);
    chk("abort_idle", o_idle, 1);
    chk("abort_busy", o_busy, 0);
    repeat (10) @(negedge i_clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_write", wr_log_addr.size(), 0);

    // Randomized instructions against the reference model.
    for (int a = 0; a < 64; a++) mem[16'(a)] = {$urandom, $urandom, $urandom, $urandom};
    for (int t = 0; t < 25; t++) begin
      run_instr(2'($urandom_range(0, 3)), 8'($urandom_range(0, 4)),
                16'($urandom_range(0, 60)), 16'($urandom_range(0, 60)), 16'($urandom_range(0, 60)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
